// File: rtl/word_puzzle_pkg.sv
// Shared types and constants for the word-scramble game engine:
// FSM state encoding, LFSR seed/taps and the difficulty-to-swap-count map.
package word_puzzle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_LATCH    = 3'd2,
      ST_SCRAMBLE = 3'd3,
      ST_FIX      = 3'd4,
      ST_PLAY     = 3'd5,
      ST_SOLVED   = 3'd6,
      ST_LOST     = 3'd7
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 (feedback from bits 0,2,3,5)
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [4:0] scramble_swaps(input logic [1:0] mode);
      return 5'd2 << mode;
   endfunction

endpackage

// File: rtl/word_puzzle_engine_lfsr16.sv
// Free-running 16-bit maximal-length LFSR used as the game's random source.
module lfsr16
   import word_puzzle_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] value
);

   // Shift right every cycle, new bit enters at the MSB
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= LFSR_SEED;
      end else begin
         value <= {^(value & LFSR_TAPS), value[15:1]};
      end
   end

endmodule

// File: rtl/word_puzzle_engine.sv
// Word-scramble game engine: fetch a random word, scramble it, then apply player swaps.
// Optional build macro MOVE_LIMIT_EN enables the move-limit LOST state.
module word_puzzle_engine
   import word_puzzle_pkg::*;
#(
   parameter  int NUM_LETTERS = 6,
   parameter  int SYM_W       = 7,
   parameter  int ROM_AW      = 6,
   parameter  int MAX_MOVES   = 15,
   localparam int IDX_W       = $clog2(NUM_LETTERS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         change,
   input  logic [IDX_W-1:0]             pos_a,
   input  logic [IDX_W-1:0]             pos_b,
   input  logic [1:0]                   mode,
   output logic [ROM_AW-1:0]            rom_addr,
   input  logic [NUM_LETTERS*SYM_W-1:0] rom_data,
   output logic [NUM_LETTERS*SYM_W-1:0] disp,
   output logic                         disp_valid,
   output logic                         is_correct,
   output logic                         game_over,
   output logic [4:0]                   move_count,
   output logic                         busy
);

   localparam logic [15:0] RND_MASK = 16'((1 << (IDX_W + 2)) - 1);

   if (NUM_LETTERS < 2 || NUM_LETTERS > 16 || MAX_MOVES < 1 || MAX_MOVES > 31) begin : g_bad_params
      $error("word_puzzle_engine: parameter out of range");
   end

   state_t                         state_r, state_s;
   logic [NUM_LETTERS*SYM_W-1:0]   word_r, word_s, disp_s;
   logic [IDX_W-1:0]               perm_r [NUM_LETTERS];
   logic [IDX_W-1:0]               perm_s [NUM_LETTERS];
   logic [4:0]                     cnt_r;
   logic [15:0]                    lfsr_s;
   logic [IDX_W-1:0]               scr_a_s, scr_braw_s, scr_b_s;
   logic                           ident_s, swap_req_s, swap_ok_s, new_game_s;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .value (lfsr_s)
   );

   // Random scramble positions; a coincident pair is pushed apart so every swap moves letters
   assign scr_a_s    = IDX_W'(int'(lfsr_s & RND_MASK) % NUM_LETTERS);
   assign scr_braw_s = IDX_W'(int'((lfsr_s >> 8) & RND_MASK) % NUM_LETTERS);
   assign scr_b_s    = (scr_braw_s == scr_a_s) ? IDX_W'((int'(scr_a_s) + 1) % NUM_LETTERS) : scr_braw_s;

   assign swap_req_s = change && (pos_a != pos_b) &&
                       (int'(pos_a) < NUM_LETTERS) && (int'(pos_b) < NUM_LETTERS);
   assign word_s     = (state_r == ST_LATCH) ? rom_data : word_r;

   // Solved detection: permutation equals identity
   always_comb begin
      ident_s = 1'b1;
      for (int i = 0; i < NUM_LETTERS; i++) begin
         ident_s = ident_s & (perm_r[i] == IDX_W'(i));
      end
   end

   // Next-state and next-permutation logic
   always_comb begin
      state_s    = state_r;
      perm_s     = perm_r;
      swap_ok_s  = 1'b0;
      new_game_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s    = ST_FETCH;
               new_game_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: state_s = ST_LATCH;
         ST_LATCH: begin
            state_s = ST_SCRAMBLE;
            for (int i = 0; i < NUM_LETTERS; i++) begin
               perm_s[i] = IDX_W'(i);
            end
         end
         ST_SCRAMBLE: begin
            perm_s[scr_a_s] = perm_r[scr_b_s];
            perm_s[scr_b_s] = perm_r[scr_a_s];
            if (cnt_r == 5'd1) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_SCRAMBLE;
            end
         end
         ST_FIX: begin
            // A scramble that cancelled itself out must not hand the player a solved word
            if (ident_s) begin
               perm_s[0] = perm_r[1];
               perm_s[1] = perm_r[0];
            end else begin
               perm_s = perm_r;
            end
            state_s = ST_PLAY;
         end
         ST_PLAY: begin
            if (start) begin
               state_s    = ST_FETCH;
               new_game_s = 1'b1;
            end else if (ident_s) begin
               state_s = ST_SOLVED;
`ifdef MOVE_LIMIT_EN
            end else if (move_count >= 5'(MAX_MOVES)) begin
               state_s = ST_LOST;
`endif
            end else if (swap_req_s) begin
               perm_s[pos_a] = perm_r[pos_b];
               perm_s[pos_b] = perm_r[pos_a];
               swap_ok_s     = 1'b1;
            end else begin
               state_s = ST_PLAY;
            end
         end
         ST_SOLVED, ST_LOST: begin
            if (start) begin
               state_s    = ST_FETCH;
               new_game_s = 1'b1;
            end else begin
               state_s = state_r;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Displayed arrangement computed from next-cycle word and permutation
   always_comb begin
      disp_s = '0;
      for (int i = 0; i < NUM_LETTERS; i++) begin
         disp_s[i*SYM_W +: SYM_W] = word_s[perm_s[i]*SYM_W +: SYM_W];
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rom_addr   <= '0;
         word_r     <= '0;
         cnt_r      <= 5'd0;
         move_count <= 5'd0;
         disp       <= '0;
         disp_valid <= 1'b0;
         is_correct <= 1'b0;
         game_over  <= 1'b0;
         busy       <= 1'b0;
         for (int i = 0; i < NUM_LETTERS; i++) begin
            perm_r[i] <= IDX_W'(i);
         end
      end else begin
         state_r <= state_s;
         word_r  <= word_s;
         perm_r  <= perm_s;
         disp    <= disp_s;
         if (new_game_s) begin
            rom_addr <= ROM_AW'(lfsr_s);
         end
         if (state_r == ST_LATCH) begin
            cnt_r <= scramble_swaps(mode);
         end else if (state_r == ST_SCRAMBLE) begin
            cnt_r <= cnt_r - 5'd1;
         end
         if (new_game_s) begin
            move_count <= 5'd0;
         end else if (swap_ok_s && (move_count != 5'd31)) begin
            move_count <= move_count + 5'd1;
         end
         disp_valid <= (state_s inside {ST_PLAY, ST_SOLVED, ST_LOST});
         is_correct <= (state_s == ST_SOLVED);
         busy       <= (state_s inside {ST_FETCH, ST_LATCH, ST_SCRAMBLE, ST_FIX});
`ifdef MOVE_LIMIT_EN
         game_over  <= (state_s == ST_LOST);
`else
         game_over  <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_word_puzzle_engine.sv
// Self-checking bench for word_puzzle_engine; honours MOVE_LIMIT_EN when defined.
module tb_word_puzzle_engine;

   localparam int N    = 6;
   localparam int SW   = 7;
   localparam int AW   = 6;
   localparam int MAXM = 15;
   localparam int IW   = $clog2(N);
   localparam int VW   = N*SW + 9;
   localparam int S_IDLE = 0, S_PLAY = 1, S_SOLVED = 2, S_LOST = 3;
`ifdef MOVE_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   logic            clk = 1'b0, rst = 1'b1, start = 1'b0, change = 1'b0;
   logic [IW-1:0]   pos_a = '0, pos_b = '0;
   logic [1:0]      mode = 2'd0;
   logic [AW-1:0]   rom_addr;
   logic [N*SW-1:0] rom_data, disp;
   logic            disp_valid, is_correct, game_over, busy;
   logic [4:0]      move_count;
   logic [VW-1:0]   obs;

   int errors = 0, checks = 0;
   int cyc = 0;
   logic [15:0] m_lfsr;
   logic [15:0] hist [4096];
   bit rom_fixed = 1'b0;
   int m_state, m_moves;
   int m_perm [N];
   logic [SW-1:0] m_word [N];

   always #5 clk = ~clk;

   word_puzzle_engine #(.NUM_LETTERS(N), .SYM_W(SW), .ROM_AW(AW), .MAX_MOVES(MAXM)) dut (
      .clk(clk), .rst(rst), .start(start), .change(change), .pos_a(pos_a), .pos_b(pos_b),
      .mode(mode), .rom_addr(rom_addr), .rom_data(rom_data), .disp(disp),
      .disp_valid(disp_valid), .is_correct(is_correct), .game_over(game_over),
      .move_count(move_count), .busy(busy));

   assign obs = {disp, move_count, disp_valid, is_correct, game_over, busy};

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      int x, fb;
      x  = int'(v);
      fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
      return 16'((x >> 1) | (fb << 15));
   endfunction

   function automatic logic [N*SW-1:0] rom_word(input logic [AW-1:0] addr, input bit fixed);
      logic [N*SW-1:0] w;
      for (int i = 0; i < N; i++)
         w[i*SW +: SW] = fixed ? SW'(i + 1) : SW'(i + 1 + (int'(addr) % 16) * 7);
      return w;
   endfunction

   function automatic bit perm_ident();
      bit id = 1'b1;
      for (int i = 0; i < N; i++) if (m_perm[i] != i) id = 1'b0;
      return id;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [N*SW-1:0] d;
      for (int i = 0; i < N; i++) d[i*SW +: SW] = m_word[m_perm[i]];
      return {d, 5'(m_moves), 1'(m_state != S_IDLE), 1'(m_state == S_SOLVED),
              1'(m_state == S_LOST), 1'b0};
   endfunction

   // LFSR reference and per-edge history, plus synchronous word ROM
   always @(posedge clk) begin
      hist[cyc % 4096] <= m_lfsr;
      cyc              <= cyc + 1;
      m_lfsr           <= rst ? 16'hACE1 : lfsr_next(m_lfsr);
      rom_data         <= rom_word(rom_addr, rom_fixed);
   end

   task automatic model_reset();
      m_state = S_IDLE; m_moves = 0;
      for (int i = 0; i < N; i++) begin m_perm[i] = i; m_word[i] = '0; end
   endtask

   task automatic play_cycle(input bit chg, input int a, input int b);
      int t;
      change = chg; pos_a = IW'(a); pos_b = IW'(b);
      @(negedge clk);
      change = 1'b0;
      if (m_state == S_PLAY) begin
         if (perm_ident()) m_state = S_SOLVED;
         else if (LIMIT_EN && m_moves >= MAXM) m_state = S_LOST;
         else if (chg && a != b && a < N && b < N) begin
            t = m_perm[a]; m_perm[a] = m_perm[b]; m_perm[b] = t;
            if (m_moves < 31) m_moves++;
         end
      end
   endtask

   task automatic start_game(input bit fixed, input logic [1:0] md, input int poke, input bit with_chg);
      int c, k, n, a, b, t;
      logic [15:0] l;
      logic [AW-1:0] addr;
      rom_fixed = fixed; mode = md; k = 2 << md;
      c = cyc; start = 1'b1;
      if (with_chg) begin change = 1'b1; pos_a = '0; pos_b = IW'(1); end
      @(negedge clk);
      start = 1'b0; change = 1'b0;
      n = 0;
      while (!disp_valid && n < 40) begin
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_setup: got %b expected 1 (cycle %0d)", busy, n); end
         if (n == poke) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      checks++;
      if (n !== k + 3) begin errors++; $display("FAIL start_latency: got %0d cycles expected %0d", n, k + 3); end
      addr = AW'(hist[c % 4096]);
      checks++;
      if (rom_addr !== addr) begin errors++; $display("FAIL rom_addr: got %h expected %h", rom_addr, addr); end
      for (int i = 0; i < N; i++) begin m_perm[i] = i; m_word[i] = SW'(rom_word(addr, fixed) >> (i*SW)); end
      for (int j = 0; j < k; j++) begin
         l = hist[(c + 3 + j) % 4096];
         a = (int'(l) % (1 << (IW + 2))) % N;
         b = ((int'(l) >> 8) % (1 << (IW + 2))) % N;
         if (a == b) b = (a + 1) % N;
         t = m_perm[a]; m_perm[a] = m_perm[b]; m_perm[b] = t;
      end
      if (perm_ident()) begin t = m_perm[0]; m_perm[0] = m_perm[1]; m_perm[1] = t; end
      m_state = S_PLAY; m_moves = 0;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL game_start: got %h expected %h", obs, exp_vec()); end
      checks++;
      if (disp === rom_word(addr, fixed)) begin errors++; $display("FAIL scrambled: got %h expected any other arrangement", disp); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      checks++;
      if (obs !== '0 || rom_addr !== '0) begin errors++; $display("FAIL reset_outputs: got %h/%h expected 0/0", obs, rom_addr); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL idle_hold: got %h expected %h", obs, exp_vec()); end
   endtask

   task automatic test_mode0_solve();
      int p [N];
      int sa [$], sb [$];
      int t;
      start_game(1'b1, 2'd0, -1, 1'b0);
      p = m_perm;
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            if (p[j] == i) begin sa.push_back(i); sb.push_back(j); t = p[i]; p[i] = p[j]; p[j] = t; end
      foreach (sa[s]) begin
         play_cycle(1'b1, sa[s], sb[s]);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL solve_step: got %h expected %h", obs, exp_vec()); end
      end
      checks++;
      if (move_count !== 5'(sa.size()) || is_correct !== 1'b0) begin
         errors++; $display("FAIL solve_moves: got %0d/%b expected %0d/0", move_count, is_correct, sa.size()); end
      play_cycle(1'b0, 0, 0);
      checks++;
      if (is_correct !== 1'b1) begin errors++; $display("FAIL solved_flag: got %b expected 1", is_correct); end
      play_cycle(1'b1, 0, 1);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL solved_hold: got %h expected %h", obs, exp_vec()); end
   endtask

   task automatic test_invalid();
      logic [N*SW-1:0] d;
      logic [4:0] mc;
      start_game(1'b0, 2'd1, -1, 1'b0);
      d = disp; mc = move_count;
      play_cycle(1'b1, 2, 2);
      checks++;
      if (disp !== d || move_count !== mc) begin errors++; $display("FAIL same_pos: got %h/%0d expected %h/%0d", disp, move_count, d, mc); end
      play_cycle(1'b1, 7, 3);
      checks++;
      if (disp !== d || move_count !== mc) begin errors++; $display("FAIL out_of_range: got %h/%0d expected %h/%0d", disp, move_count, d, mc); end
      play_cycle(1'b1, 0, 5);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL valid_after_invalid: got %h expected %h", obs, exp_vec()); end
   endtask

   task automatic test_start_wins();
      start_game(1'b0, 2'd1, -1, 1'b1);
   endtask

   task automatic test_start_in_scramble();
      start_game(1'b0, 2'd2, 4, 1'b0);
   endtask

   task automatic test_move_limit();
      int x = 0, y = 1, t;
      bit found = 1'b0;
      start_game(1'b0, 2'd0, -1, 1'b0);
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++) begin
            t = m_perm[i]; m_perm[i] = m_perm[j]; m_perm[j] = t;
            if (!found && !perm_ident()) begin x = i; y = j; found = 1'b1; end
            t = m_perm[i]; m_perm[i] = m_perm[j]; m_perm[j] = t;
         end
      for (int s = 0; s < 35; s++) begin
         play_cycle(1'b1, x, y);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL toggle_swap: got %h expected %h", obs, exp_vec()); end
      end
      checks++;
`ifdef MOVE_LIMIT_EN
      if (move_count !== 5'(MAXM) || game_over !== 1'b1) begin
         errors++; $display("FAIL move_limit: got %0d/%b expected %0d/1", move_count, game_over, MAXM); end
`else
      if (move_count !== 5'd31 || game_over !== 1'b0) begin
         errors++; $display("FAIL move_saturate: got %0d/%b expected 31/0", move_count, game_over); end
`endif
      start_game(1'b0, 2'd3, -1, 1'b0);
   endtask

   task automatic test_random_play();
      for (int g = 0; g < 4; g++) begin
         start_game(1'b0, 2'($urandom_range(0, 3)), -1, 1'b0);
         for (int s = 0; s < 30; s++) begin
            play_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random_play: got %h expected %h", obs, exp_vec()); end
         end
      end
   endtask

   task automatic test_rst_mid();
      mode = 2'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      checks++;
      if (obs !== '0 || rom_addr !== '0) begin errors++; $display("FAIL reset_mid_scramble: got %h/%h expected 0/0", obs, rom_addr); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL idle_after_reset: got %h expected %h", obs, exp_vec()); end
   endtask

   initial begin
      test_reset();
      test_mode0_solve();
      test_invalid();
      test_start_wins();
      test_start_in_scramble();
      test_move_limit();
      test_random_play();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
